pe_row_mac: RTL

Parametrised row-stationary processing element for the systolic convolution array. Each job convolves one FIL_S-tap filter row with one DI_W-wide ifmap row per input channel, over NUM_CH channels. All channels accumulate into DO_W partial sums, seeded by an incoming psum row. A single time-multiplexed MAC does the work. Job input and result output use valid/ready handshakes, and the result path applies saturation and optional ReLU, so PEs chain vertically without external glue.

---
 rtl/pe_row_mac_pkg.sv | 44 ++++
 rtl/pe_row_mac_mac.sv | 26 ++
 rtl/pe_row_mac.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/pe_row_mac_pkg.sv
// Shared types and helpers for the row-stationary PE: FSM states,
// accumulator sizing and the output clamp.
package pe_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MAC     = 3'd1,
        ST_WAIT_CH = 3'd2,
        ST_FINAL   = 3'd3,
        ST_OUT     = 3'd4
    } pe_state_t;

    localparam int CLAMP_W = 64;

    typedef struct packed {
        logic                      sat;
        logic signed [CLAMP_W-1:0] val;
    } clamp_t;

    // Full product width plus enough headroom for every tap of every channel and the seed.
    function automatic int acc_width(input int data_w, input int fil_s, input int num_ch);
        return 32'sd2 * data_w + $clog2(fil_s * num_ch + 32'sd1) + 32'sd1;
    endfunction

    function automatic clamp_t clamp(input logic signed [CLAMP_W-1:0] v, input int data_w);
        logic signed [CLAMP_W-1:0] hi;
        logic signed [CLAMP_W-1:0] lo;
        clamp_t                    r;
        hi = (64'sd1 <<< (data_w - 32'sd1)) - 64'sd1;
        lo = -(64'sd1 <<< (data_w - 32'sd1));
        if (v > hi) begin
            r.sat = 1'b1;
            r.val = hi;
        end else if (v < lo) begin
            r.sat = 1'b1;
            r.val = lo;
        end else begin
            r.sat = 1'b0;
            r.val = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/pe_row_mac_mac.sv
// Single signed multiplier with an accumulate-select adder; the caller
// owns the accumulator registers.
module pe_mac #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 35
) (
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    input  logic signed [ACC_W-1:0]  acc_in,
    input  logic                     en,
    output logic signed [ACC_W-1:0]  acc_out
);

    logic signed [2*DATA_W-1:0] prod;

    // Full-width product, sign-extended into the accumulator when enabled.
    always_comb begin
        prod = a * b;
        if (en) begin
            acc_out = acc_in + ACC_W'(prod);
        end else begin
            acc_out = acc_in;
        end
    end

endmodule

// File: rtl/pe_row_mac.sv
// Row-stationary PE: time-multiplexed MAC over FIL_S taps x DO_W outputs per
// channel, psum seeding, then saturating (optionally rectified) result row.
module pe_row_mac
    import pe_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FIL_S  = 3,
    parameter int DI_W   = 7,
    parameter int NUM_CH = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [FIL_S-1:0][DATA_W-1:0]        filter_in,
    input  logic [DI_W-1:0][DATA_W-1:0]         data_in,
    input  logic [DI_W-FIL_S:0][DATA_W-1:0]     psum_in,
    input  logic                                relu_en,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [DI_W-FIL_S:0][DATA_W-1:0]     psum_out,
    output logic                                sat_flag
);

    localparam int DO_W  = DI_W - FIL_S + 1;
    localparam int ACC_W = acc_width(DATA_W, FIL_S, NUM_CH);
    localparam int KW    = (FIL_S  > 1) ? $clog2(FIL_S)  : 1;
    localparam int JW    = (DO_W   > 1) ? $clog2(DO_W)   : 1;
    localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int IW    = (DI_W   > 1) ? $clog2(DI_W)   : 1;

    pe_state_t                     state_r;
    logic [KW-1:0]                 k_r;
    logic [JW-1:0]                 j_r;
    logic [CW-1:0]                 ch_r;
    logic                          relu_r;
    logic [FIL_S-1:0][DATA_W-1:0]  filter_r;
    logic [DI_W-1:0][DATA_W-1:0]   data_r;
    logic signed [ACC_W-1:0]       acc_r [DO_W];

    logic [IW-1:0]                 idx_s;
    logic signed [DATA_W-1:0]      mac_a_s;
    logic signed [DATA_W-1:0]      mac_b_s;
    logic signed [ACC_W-1:0]       mac_acc_s;
    logic                          mac_en_s;
    logic signed [ACC_W-1:0]       mac_out_s;
    clamp_t                        cl_s;
    logic [DATA_W-1:0]             res_s [DO_W];
    logic                          sat_any_s;

    // Handshake flags decode straight from the state register; in_ready drops while rst is held.
    always_comb begin
        in_ready  = !rst && ((state_r == ST_IDLE) || (state_r == ST_WAIT_CH));
        out_valid = (state_r == ST_OUT);
    end

    // Operand select for the shared MAC: tap k of the filter against ifmap element j+k.
    always_comb begin
        idx_s     = IW'(j_r) + IW'(k_r);
        mac_a_s   = $signed(filter_r[k_r]);
        mac_b_s   = $signed(data_r[idx_s]);
        mac_acc_s = acc_r[j_r];
        mac_en_s  = (state_r == ST_MAC);
    end

    pe_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .a       (mac_a_s),
        .b       (mac_b_s),
        .acc_in  (mac_acc_s),
        .en      (mac_en_s),
        .acc_out (mac_out_s)
    );

    // Clamp each accumulator to DATA_W, then rectify; saturation is flagged before rectification.
    always_comb begin
        sat_any_s = 1'b0;
        cl_s      = '0;
        for (int i = 0; i < DO_W; i++) begin
            cl_s      = clamp(CLAMP_W'(acc_r[i]), DATA_W);
            sat_any_s = sat_any_s | cl_s.sat;
            if (relu_r && ($signed(cl_s.val) < 64'sd0)) begin
                res_s[i] = '0;
            end else begin
                res_s[i] = cl_s.val[DATA_W-1:0];
            end
        end
    end

    // Job sequencer: accept beats, sweep j (outer) and k (inner), finalise, hold result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            k_r      <= '0;
            j_r      <= '0;
            ch_r     <= '0;
            relu_r   <= 1'b0;
            filter_r <= '0;
            data_r   <= '0;
            psum_out <= '0;
            sat_flag <= 1'b0;
            for (int i = 0; i < DO_W; i++) begin
                acc_r[i] <= '0;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        filter_r <= filter_in;
                        data_r   <= data_in;
                        relu_r   <= relu_en;
                        ch_r     <= '0;
                        k_r      <= '0;
                        j_r      <= '0;
                        for (int i = 0; i < DO_W; i++) begin
                            acc_r[i] <= ACC_W'($signed(psum_in[i]));
                        end
                        state_r  <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    acc_r[j_r] <= mac_out_s;
                    if (k_r == KW'(FIL_S - 1)) begin
                        k_r <= '0;
                        if (j_r == JW'(DO_W - 1)) begin
                            j_r <= '0;
                            if (ch_r < CW'(NUM_CH - 1)) begin
                                state_r <= ST_WAIT_CH;
                            end else begin
                                state_r <= ST_FINAL;
                            end
                        end else begin
                            j_r <= j_r + JW'(1);
                        end
                    end else begin
                        k_r <= k_r + KW'(1);
                    end
                end
                ST_WAIT_CH: begin
                    if (in_valid) begin
                        filter_r <= filter_in;
                        data_r   <= data_in;
                        ch_r     <= ch_r + CW'(1);
                        state_r  <= ST_MAC;
                    end
                end
                ST_FINAL: begin
                    for (int i = 0; i < DO_W; i++) begin
                        psum_out[i] <= res_s[i];
                    end
                    sat_flag <= sat_any_s;
                    state_r  <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
